// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed 7-segment scan controller with a double-
//               buffered digit word, a shared external decoder and anode
//               blanking between digits. Define SEG7_DP_EN to add per-digit
//               decimal-point ports (dp_in / dp_out).
// Revision    : 1.0
// =============================================================================
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              nibble_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an,
`ifdef SEG7_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp_out,
`endif
    output logic                    frame_done
);

    localparam int c_CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = $clog2(NUM_DIGITS);
    localparam int c_WORD_W  = 4 * NUM_DIGITS;

    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DRIVE_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_WORD_W-1:0]     r_active;
    logic [c_WORD_W-1:0]     r_pending;
    logic                    r_pend_full;
    logic [c_IDX_W-1:0]      r_idx;
    logic [c_IDX_W-1:0]      w_idx_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic                    w_swap;
    logic                    w_seg_ld;
    logic                    w_xfer;

    assign load_ready = ~r_pend_full & ~rst;
    assign w_xfer     = load_valid & load_ready;
    assign nibble_out = r_active[{r_idx, 2'b00} +: 4];
    assign seg_out    = r_seg;
    assign an         = r_an;
    assign frame_done = w_swap & ~rst;

    // Pending word is promoted only from OFF or on the last DRIVE cycle of
    // the last digit, so the displayed word never changes mid-frame.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_swap      = 1'b0;
        w_seg_ld    = 1'b0;
        case (r_state)
            ST_OFF: begin
                w_cnt_nxt = '0;
                if (r_pend_full) begin
                    w_swap      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_seg_ld    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == c_DRIVE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_BLANK;
                    if (r_idx == c_IDX_LAST) begin
                        w_idx_nxt = '0;
                        w_swap    = r_pend_full;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // Anodes are registered from next-state so they line up with r_state.
    always_comb begin
        w_an_nxt = '1;
        if (w_state_nxt == ST_DRIVE && digit_en[w_idx_nxt]) begin
            w_an_nxt[w_idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_OFF;
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_seg       <= 7'h00;
            r_an        <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_an    <= w_an_nxt;
            if (w_xfer) begin
                r_pending   <= load_data;
                r_pend_full <= 1'b1;
            end else if (w_swap) begin
                r_pend_full <= 1'b0;
            end
            if (w_swap) begin
                r_active <= r_pending;
            end
            if (w_seg_ld) begin
                r_seg <= seg_in;
            end
        end
    end

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0] r_dp_pend;
    logic [NUM_DIGITS-1:0] r_dp_act;
    logic                  r_dp_out;

    assign dp_out = r_dp_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_pend <= '0;
            r_dp_act  <= '0;
            r_dp_out  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_dp_pend <= dp_in;
            end
            if (w_swap) begin
                r_dp_act <= r_dp_pend;
            end
            if (w_seg_ld) begin
                r_dp_out <= r_dp_act[r_idx];
            end else if (w_state_nxt != ST_DRIVE) begin
                r_dp_out <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Directed self-checking bench for seg7_scan_ctrl
//               (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// Revision    : 1.0
// =============================================================================
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  digit_en;
    logic [3:0]  nibble_out;
    logic [6:0]  seg_in;
    logic [6:0]  seg_out;
    logic [3:0]  an;
    logic        frame_done;
`ifdef SEG7_DP_EN
    logic [3:0]  dp_in;
    logic        dp_out;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          ncyc     = 0;
    bit          armed    = 1'b0;
    logic [15:0] host_q[$];
    logic [15:0] staged_q[$];
    int          acc_cyc[$];

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .digit_en   (digit_en),
        .nibble_out (nibble_out),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .an         (an),
`ifdef SEG7_DP_EN
        .dp_in      (dp_in),
        .dp_out     (dp_out),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // External hex decoder, segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 7'h3F;  4'h1: dec = 7'h06;  4'h2: dec = 7'h5B;  4'h3: dec = 7'h4F;
            4'h4: dec = 7'h66;  4'h5: dec = 7'h6D;  4'h6: dec = 7'h7D;  4'h7: dec = 7'h07;
            4'h8: dec = 7'h7F;  4'h9: dec = 7'h6F;  4'hA: dec = 7'h77;  4'hB: dec = 7'h7C;
            4'hC: dec = 7'h39;  4'hD: dec = 7'h5E;  4'hE: dec = 7'h79;  default: dec = 7'h71;
        endcase
    endfunction

    assign seg_in = dec(nibble_out);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, ncyc, got, exp);
        end
    endtask

    // Advance to the next falling edge and run the host side of the handshake.
    task automatic step();
        @(negedge clk);
        ncyc++;
        if (armed) begin
            acc_cyc.push_back(ncyc - 1);
            host_q.delete(0);
        end
        if (host_q.size() != 0) begin
            load_valid = 1'b1;
            load_data  = host_q[0];
        end else begin
            load_valid = 1'b0;
        end
        armed = load_valid && (load_ready === 1'b1);
    endtask

    task automatic run_frame(input logic [15:0] word, input logic [3:0] en,
                             input bit fd_last, input int push_k);
        logic [3:0] nib;
        logic [3:0] exp_an;
        logic       exp_fd;
        digit_en = en;
        for (int k = 0; k < ND; k++) begin
            nib = word[4*k +: 4];
            if (k == push_k) begin
                while (staged_q.size() != 0) begin
                    host_q.push_back(staged_q[0]);
                    staged_q.delete(0);
                end
            end
            for (int b = 0; b < BC; b++) begin
                step();
                check("blank_an", 32'(an), 32'hF);
                check("blank_nib", 32'(nibble_out), 32'(nib));
                check("blank_fd", 32'(frame_done), 32'h0);
`ifdef SEG7_DP_EN
                check("blank_dp", 32'(dp_out), 32'h0);
`endif
            end
            exp_an = 4'hF;
            if (en[k]) exp_an[k] = 1'b0;
            for (int d = 0; d < RD; d++) begin
                step();
                exp_fd = (k == ND - 1 && d == RD - 1) ? fd_last : 1'b0;
                check("drive_an", 32'(an), 32'(exp_an));
                check("drive_seg", 32'(seg_out), 32'(dec(nib)));
                check("drive_nib", 32'(nibble_out), 32'(nib));
                check("drive_fd", 32'(frame_done), 32'(exp_fd));
`ifdef SEG7_DP_EN
                check("drive_dp", 32'(dp_out), (k == 1) ? 32'h1 : 32'h0);
`endif
            end
        end
    endtask

    initial begin
        int l_cyc;
        int f1;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0;
        digit_en   = 4'hF;
`ifdef SEG7_DP_EN
        dp_in      = 4'b0010;
`endif
        repeat (3) step();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg_out), 32'h0);
        check("rst_ready", 32'(load_ready), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst_nib", 32'(nibble_out), 32'h0);
        rst = 1'b0;
        step();
        check("off_ready", 32'(load_ready), 32'h1);
        check("off_an", 32'(an), 32'hF);
        step();
        check("off_an2", 32'(an), 32'hF);
        check("off_fd", 32'(frame_done), 32'h0);

        // First word: frame_done the cycle after the transfer, then frame 1.
        host_q.push_back(16'h1234);
        step();
        l_cyc = ncyc;
        step();
        check("load_fd", 32'(frame_done), 32'h1);
        check("load_ready_full", 32'(load_ready), 32'h0);
        check("load_an", 32'(an), 32'hF);
        f1 = ncyc + 1;

        // Two more words offered during digit 1: second accepted at once,
        // third stalls until the cycle after the frame boundary.
        staged_q.push_back(16'hABCD);
        staged_q.push_back(16'h5678);
        run_frame(16'h1234, 4'hF, 1'b1, 1);
        run_frame(16'hABCD, 4'hF, 1'b1, -1);
        check("acc_count", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            check("acc_first", 32'(acc_cyc[0]), 32'(l_cyc));
            check("acc_mid", 32'(acc_cyc[1]), 32'(f1 + 10));
            check("acc_after_bnd", 32'(acc_cyc[2]), 32'(f1 + 40));
        end

        // Sparse enables: digits 1 and 3 stay dark, period unchanged.
        run_frame(16'h5678, 4'b0101, 1'b0, -1);
        run_frame(16'h5678, 4'b0101, 1'b0, -1);

        // Load a word, then reset during DRIVE of digit 2.
        host_q.push_back(16'h9999);
        repeat (2 * (BC + RD) + BC + 3) step();
        check("pre_rst_an", 32'(an), 32'hB);
        check("pre_rst_seg", 32'(seg_out), 32'(dec(4'h6)));
        check("pre_rst_ready", 32'(load_ready), 32'h0);
        rst = 1'b1;
        step();
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg_out), 32'h0);
        check("mid_rst_ready", 32'(load_ready), 32'h0);
        check("mid_rst_nib", 32'(nibble_out), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("post_rst_an", 32'(an), 32'hF);
            check("post_rst_fd", 32'(frame_done), 32'h0);
            check("post_rst_ready", 32'(load_ready), 32'h1);
            check("post_rst_seg", 32'(seg_out), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit 7-segment display. One combinational hex-to-segment decoder is shared across all digits. The controller holds a double-buffered digit word and presents one nibble at a time to the decoder. It registers the decoder's 7-bit pattern and drives the common anodes with blanking dead-time between digits, so ghosting and tearing cannot occur. It sits between the host logic that produces the digit values and the display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clk cycles each digit is driven (>=1)
BLANK_CYCLES, 4, clk cycles all anodes are off before each digit (>=1)

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
load_valid  in  1  host offers a new display word
load_ready  out  1  controller can accept a word
load_data  in  4*NUM_DIGITS  digit k = load_data[4k+3:4k]
digit_en  in  NUM_DIGITS  per-digit enable, sampled live
nibble_out  out  4  {a,b,c,d} to the shared decoder; bit 3 = a
seg_in  in  7  decoder segment pattern Q[6:0]
seg_out  out  7  registered segment drive, same polarity as seg_in
an  out  NUM_DIGITS  anode select, active-low
frame_done  out  1  one-cycle pulse when a pending word becomes active

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst. No other clock or async reset.
- Registers:
  - active[4*NUM_DIGITS-1:0]
  - pending[4*NUM_DIGITS-1:0]
  - pending_full
  - digit_idx
  - phase counter cnt
  - state in {OFF, BLANK, DRIVE}
- Reset values:
  - state=OFF, active=0, pending=0, pending_full=0, digit_idx=0, cnt=0.
  - an=all 1s, seg_out=7'h00, nibble_out=0, frame_done=0.
  - load_ready=0 while rst is high.
- Handshake:
  - load_ready = ~pending_full & ~rst.
  - Transfer occurs on a cycle with load_valid & load_ready: pending<=load_data and pending_full<=1.
  - load_data must be held while valid & !ready.
- OFF:
  - an all 1s; seg_out holds its value.
  - If pending_full: active<=pending, pending_full<=0, frame_done=1, digit_idx<=0, cnt<=0, goto BLANK.
- BLANK:
  - an all 1s; nibble_out=active[4*digit_idx+:4].
  - Lasts BLANK_CYCLES cycles.
  - On its last cycle: seg_out<=seg_in, cnt<=0, goto DRIVE.
- DRIVE:
  - an[digit_idx]=0 if digit_en[digit_idx], else all anodes stay 1. All other anodes are 1.
  - Lasts REFRESH_DIV cycles, then cnt<=0 and goto BLANK with digit_idx+1.
  - Wrap: after digit NUM_DIGITS-1, digit_idx<=0. This is the frame boundary.
- Frame boundary:
  - If pending_full: active<=pending, pending_full<=0, frame_done pulses for that cycle.
  - Otherwise active is unchanged and no pulse is issued.
  - active never changes mid-frame.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles. Digit order is 0..NUM_DIGITS-1.
- Decode latency: nibble_out is stable for all of BLANK; seg_out is updated at the BLANK→DRIVE edge. seg_out must not change during DRIVE.
- Boundary-cycle load: load_ready is 0 on the boundary cycle when pending_full. It returns to 1 the following cycle. A word is never lost or double-applied.
- digit_en changes take effect on the next cycle and never alter timing.
- rst mid-operation: return to OFF on the next edge and discard pending.

Optional Feature:
SEG7_DP_EN
- Defined:
  - Adds input dp_in[NUM_DIGITS-1:0] and output dp_out (active-high).
  - dp_in is double-buffered with load_data, captured on the same handshake.
  - dp_out<=dp of digit_idx at the BLANK→DRIVE edge; 0 in OFF and BLANK; 0 on reset.
- Undefined: no dp ports and no dp storage.

Test Plan:
- Reset (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2): rst high for 3 cycles -> an=4'hF, seg_out=0, load_ready=0. After release, load_ready=1 and an stays 4'hF (OFF).
- Load 16'h1234, digit_en=4'hF:
  - Transfer, then frame_done pulse next cycle.
  - nibble_out sequence 4,3,2,1.
  - an sequence 1110,1101,1011,0111, each low for 8 cycles after 2 blank cycles of 1111.
  - Frame = 40 cycles.
  - seg_out equals the decoder pattern for each nibble throughout DRIVE.
- Tearing:
  - Load 16'hABCD during digit 1 of frame 1: accepted; nibbles stay 4,3,2,1 through the end of frame 1.
  - Frame 2 shows D,C,B,A with frame_done at the boundary.
  - A third load issued mid-frame sees load_ready=0 until one cycle after the boundary.
- digit_en=4'b0101: an=1111 during the DRIVE slots of digits 1 and 3; frame period is still 40 cycles.
- rst asserted in DRIVE of digit 2: next cycle an=4'hF, state OFF, pending cleared. No output until a new load.
- SEG7_DP_EN with dp_in=4'b0010: dp_out=1 only during the DRIVE of digit 1; 0 in all BLANK cycles.
